// File: rtl/io_port.sv
// ---------------------------------------------------------------------------
// io_port
//
// Memory-mapped I/O peripheral sitting between the CPU core and the board
// switches/LEDs. Raw switch inputs pass through a two-flop synchroniser and a
// whole-vector debouncer. An accepted change raises a sticky change flag,
// which can also raise an interrupt. The CPU writes and reads back an LED
// register that drives the LED pins directly.
//
// Ports
//   clock     in   1      system clock, all logic on the rising edge
//   reset     in   1      synchronous, active-low reset
//   switches  in   WIDTH  raw asynchronous switch inputs
//   LEDs      out  WIDTH  LED drive, equal to the LED register
//   addr      in   2      register select: 0 SWITCH, 1 LED, 2 STATUS, 3 CONTROL
//   wr_en     in   1      one-cycle write strobe
//   wr_data   in   8      write data
//   rd_en     in   1      one-cycle read strobe
//   rd_data   out  8      registered read data, held between reads
//   rd_valid  out  1      one-cycle pulse, rd_data valid
//   irq       out  1      change_flag AND irq_en
//
// Register map (unused upper bits read 0)
//   0 SWITCH   R : debounced switch value; a read clears change_flag
//   1 LED      RW: LED register
//   2 STATUS   R : {irq_en, change_flag}
//   3 CONTROL  W : bit1 irq_en, bit0 = 1 clears change_flag; reads 0
// ---------------------------------------------------------------------------
module io_port #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] LEDs,
    input  logic [1:0]       addr,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             irq
);

    typedef enum logic [1:0] {
        ADDR_SWITCH  = 2'd0,
        ADDR_LED     = 2'd1,
        ADDR_STATUS  = 2'd2,
        ADDR_CONTROL = 2'd3
    } reg_addr_t;

    localparam int             CW      = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] stable;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] led_reg;
    logic             change_flag;
    logic             irq_en;

    logic             accept;
    logic             flag_clear;
    logic [7:0]       rd_mux;
    reg_addr_t        sel;

    // Only the low bits of wr_data reach a register for small WIDTH; this
    // keeps the rest of the bus consumed.
    logic             unused_wr_data;
    assign unused_wr_data = ^wr_data;

    assign sel = reg_addr_t'(addr);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        accept     = (s2 != stable) && (count == CNT_MAX);
        flag_clear = (rd_en && sel == ADDR_SWITCH) ||
                     (wr_en && sel == ADDR_CONTROL && wr_data[0]);

        // Read mux sees the pre-edge register values, so a read that
        // coincides with a write or an acceptance returns the old value.
        rd_mux = '0;
        case (sel)
            ADDR_SWITCH:  rd_mux[WIDTH-1:0] = stable;
            ADDR_LED:     rd_mux[WIDTH-1:0] = led_reg;
            ADDR_STATUS:  rd_mux[1:0]       = {irq_en, change_flag};
            default:      rd_mux            = '0;
        endcase
    end

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1          <= '0;
            s2          <= '0;
            stable      <= '0;
            count       <= '0;
            led_reg     <= '0;
            change_flag <= 1'b0;
            irq_en      <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
        end else begin
            s1 <= switches;
            s2 <= s1;

            // The count only advances while the synchronised vector differs
            // from the accepted one; any return to stable restarts it.
            if (s2 == stable) begin
                count <= '0;
            end else if (accept) begin
                stable <= s2;
                count  <= '0;
            end else begin
                count <= count + 1'b1;
            end

            // Set beats clear when an acceptance lands on a clearing access.
            if (accept) begin
                change_flag <= 1'b1;
            end else if (flag_clear) begin
                change_flag <= 1'b0;
            end

            if (wr_en) begin
                case (sel)
                    ADDR_LED:     led_reg <= wr_data[WIDTH-1:0];
                    ADDR_CONTROL: irq_en  <= wr_data[1];
                    default:      ;
                endcase
            end

            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux;
            end
        end
    end

    assign LEDs = led_reg;
    assign irq  = change_flag & irq_en;

endmodule

// File: tb/tb_io_port.sv
// ---------------------------------------------------------------------------
// tb_io_port
//
// Self-checking bench for io_port. Each call to step() drives one cycle of
// inputs, advances a behavioural model of the register map, and compares the
// DUT outputs one time unit after the rising edge.
//
// The debounce model works on the recorded input history: the synchronised
// value seen at edge k is the input that was present two edges earlier
// (zero if either of those edges was a reset edge), and a change is accepted
// at edge k when the synchronised value differed from the accepted value at
// each of the last DEBOUNCE_CYCLES edges, all of them after the previous
// acceptance or reset.
// ---------------------------------------------------------------------------
module tb_io_port;

    localparam int W    = 4;
    localparam int D    = 4;
    localparam int MAXE = 8192;

    logic         clock;
    logic         reset;
    logic [W-1:0] switches;
    logic [W-1:0] LEDs;
    logic [1:0]   addr;
    logic         wr_en;
    logic [7:0]   wr_data;
    logic         rd_en;
    logic [7:0]   rd_data;
    logic         rd_valid;
    logic         irq;

    io_port #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .switches (switches),
        .LEDs     (LEDs),
        .addr     (addr),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    logic [W-1:0] sw_h  [MAXE];
    bit           rst_h [MAXE];
    int           k        = 0;
    int           last_evt = -100;
    logic [W-1:0] stable_m = '0;
    logic [W-1:0] led_m    = '0;
    logic         flag_m   = 1'b0;
    logic         irq_en_m = 1'b0;
    logic [7:0]   rdd_m    = '0;
    logic         rdv_m    = 1'b0;

    function automatic logic [W-1:0] synced_at(input int e);
        if (e < 2) return '0;
        if (rst_h[e-1] || rst_h[e-2]) return '0;
        return sw_h[e-2];
    endfunction

    task automatic step(input logic [W-1:0] sw, input bit rst, input logic [1:0] a,
                        input bit rd, input bit wr, input logic [7:0] wd);
        bit         acc;
        bit         clr;
        logic [7:0] rv;
        if (k >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected below %0d", k, MAXE);
            $fatal(1, "edge budget exhausted");
        end
        switches = sw;
        reset    = ~rst;
        addr     = a;
        rd_en    = rd;
        wr_en    = wr;
        wr_data  = wd;
        @(posedge clock);
        sw_h[k]  = sw;
        rst_h[k] = rst;
        if (rst) begin
            stable_m = '0; led_m = '0; flag_m = 1'b0; irq_en_m = 1'b0;
            rdd_m = '0; rdv_m = 1'b0; last_evt = k;
        end else begin
            acc = (k - last_evt >= D);
            for (int j = 0; j < D; j++)
                if (synced_at(k - j) == stable_m) acc = 1'b0;
            rv = 8'h00;
            case (a)
                2'd0: rv = 8'(stable_m);
                2'd1: rv = 8'(led_m);
                2'd2: rv = {6'b0, irq_en_m, flag_m};
                default: rv = 8'h00;
            endcase
            rdv_m = rd;
            if (rd) rdd_m = rv;
            clr = (rd && a == 2'd0) || (wr && a == 2'd3 && wd[0]);
            if (wr && a == 2'd1) led_m = wd[W-1:0];
            if (wr && a == 2'd3) irq_en_m = wd[1];
            if (acc) begin
                flag_m   = 1'b1;
                stable_m = synced_at(k);
                last_evt = k;
            end else if (clr) begin
                flag_m = 1'b0;
            end
        end
        k++;
        #1;
        check("leds",     32'(LEDs),     32'(led_m));
        check("rd_valid", 32'(rd_valid), 32'(rdv_m));
        check("rd_data",  32'(rd_data),  32'(rdd_m));
        check("irq",      32'(irq),      32'(flag_m & irq_en_m));
    endtask

    logic [W-1:0] cur_sw = '0;

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(cur_sw, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic rd_reg(input logic [1:0] a);
        step(cur_sw, 1'b0, a, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
        step(cur_sw, 1'b0, a, 1'b0, 1'b1, d);
    endtask

    initial begin
        switches = '0; reset = 1'b0; addr = '0;
        rd_en = 1'b0; wr_en = 1'b0; wr_data = '0;

        // Reset with activity on the inputs
        cur_sw = 4'b1111;
        step(cur_sw, 1'b1, 2'd1, 1'b1, 1'b1, 8'hFF);
        step(cur_sw, 1'b1, 2'd1, 1'b1, 1'b1, 8'hFF);
        check("rst_leds",     32'(LEDs),     32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_irq",      32'(irq),      32'h0);

        // Acceptance of 1111 lands exactly on the 6th edge after release
        idle(5);
        rd_reg(2'd2);
        check("e6_status_pre", 32'(rd_data), 32'h00);
        rd_reg(2'd2);
        check("e7_status_flag", 32'(rd_data), 32'h01);
        rd_reg(2'd0);
        check("e8_switch", 32'(rd_data), 32'h0F);
        rd_reg(2'd2);
        check("flag_cleared", 32'(rd_data), 32'h00);

        // Debounce filter: a 3-edge pulse is rejected
        cur_sw = 4'b0000; idle(8); rd_reg(2'd0);
        cur_sw = 4'b0101; idle(3);
        cur_sw = 4'b0000; idle(10);
        rd_reg(2'd0);
        check("bounce_stable", 32'(rd_data), 32'h00);
        rd_reg(2'd2);
        check("bounce_flag", 32'(rd_data), 32'h00);

        // Held 0101 accepted at E6; a read at E6 sees the old value
        cur_sw = 4'b0101; idle(5);
        rd_reg(2'd0);
        check("e6_read_old", 32'(rd_data), 32'h00);
        rd_reg(2'd2);
        check("e6_set_wins", 32'(rd_data), 32'h01);
        rd_reg(2'd0);
        check("held_0101", 32'(rd_data), 32'h05);

        // Read and clear
        cur_sw = 4'b0011; idle(8);
        rd_reg(2'd0);
        check("read_0011", 32'(rd_data), 32'h03);
        check("read_0011_valid", 32'(rd_valid), 32'h1);
        rd_reg(2'd2);
        check("status_after_clear", 32'(rd_data), 32'h00);

        // LED write and readback
        wr_reg(2'd1, 8'hFA);
        check("led_write", 32'(LEDs), 32'hA);
        rd_reg(2'd1);
        check("led_readback", 32'(rd_data), 32'h0A);

        // Simultaneous read and write return the pre-write value
        step(cur_sw, 1'b0, 2'd1, 1'b1, 1'b1, 8'h05);
        check("rw_same_cycle", 32'(rd_data), 32'h0A);
        check("rw_led_new", 32'(LEDs), 32'h5);

        // Interrupt
        wr_reg(2'd3, 8'h02);
        cur_sw = 4'b1001; idle(8);
        check("irq_set", 32'(irq), 32'h1);
        wr_reg(2'd3, 8'h03);
        check("irq_cleared", 32'(irq), 32'h0);
        rd_reg(2'd2);
        check("irq_en_kept", 32'(rd_data), 32'h02);

        // Collision: acceptance edge coincides with an addr0 read
        cur_sw = 4'b0110; idle(5);
        rd_reg(2'd0);
        check("collide_old", 32'(rd_data), 32'h09);
        check("collide_irq", 32'(irq), 32'h1);
        rd_reg(2'd2);
        check("collide_status", 32'(rd_data), 32'h03);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) cur_sw = W'($urandom);
            step(cur_sw,
                 ($urandom_range(0, 199) == 0),
                 2'($urandom),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
